core_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the RV core. It owns the PC and instruction register and drives the fetch, decode, execute, memory and writeback phases around the combinational instruction decoder. It handshakes with instruction and data memory and gates register-file writes. It traps to a halt state on illegal opcodes, misaligned jump targets, environment calls and bus timeouts.

---
 rtl/core_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_core_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV core.
// Owns pc and the instruction register, handshakes with instruction and data
// memory, gates register-file writes and traps into an absorbing HALT state.
// Optional feature macro: CORE_SEQ_INSTRET_EN builds the retired-instruction
// counter; without it instret is tied to 0.
module core_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned BUS_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [6:0]  opcode,
    input  logic        RegWriteEn,
    input  logic        MemWrite,
    input  logic [1:0]  PCSel,
    input  logic        branch_taken,
    input  logic [31:0] target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halt,
    output logic [2:0]  trap_cause,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] CAUSE_ILLEGAL   = 3'd1;
    localparam logic [2:0] CAUSE_MISALIGN  = 3'd2;
    localparam logic [2:0] CAUSE_ECALL     = 3'd3;
    localparam logic [2:0] CAUSE_TIMEOUT   = 3'd4;

    // Wait counter only needs to reach BUS_TIMEOUT-1; the cycle it would
    // reach BUS_TIMEOUT without an ack is the timeout cycle.
    localparam int             WCW        = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(BUS_TIMEOUT - 1);
    localparam logic           TIMEOUT_EN = (BUS_TIMEOUT != 0);

    state_t         state_reg;
    logic [31:0]    pc_reg;
    logic [31:0]    instr_reg;
    logic [2:0]     cause_reg;
    logic [WCW-1:0] wait_reg;

    logic [31:0]    next_pc;
    logic           next_pc_misaligned;
    logic           opcode_legal;
    logic           wait_expired;
    logic           retire;

    // The decoder's PC select is redundant with the opcode-based PC rules.
    logic           unused_pcsel;
    assign unused_pcsel = ^PCSel;

    assign pc_plus4     = pc_reg + 32'd4;
    assign wait_expired = TIMEOUT_EN && (wait_reg == WAIT_LAST);
    assign retire       = (state_reg == S_WB) && !next_pc_misaligned;

    // Classify the decoded opcode into the set the core can execute.
    always_comb begin
        opcode_legal = 1'b0;
        case (opcode)
            7'h03, 7'h13, 7'h1b, 7'h17, 7'h37, 7'h63, 7'h6f, 7'h23: opcode_legal = 1'b1;
            default: opcode_legal = 1'b0;
        endcase
    end

    // Select the PC that WB would commit: jal always jumps, branches jump when taken.
    always_comb begin
        next_pc = pc_plus4;
        if (opcode == 7'h6f) begin
            next_pc = target;
        end else if ((opcode == 7'h63) && branch_taken) begin
            next_pc = target;
        end
        next_pc_misaligned = (next_pc[1:0] != 2'b00);
    end

    // Main sequencer: phase transitions, pc/instr updates, trap capture and bus wait counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
            pc_reg    <= RESET_VECTOR;
            instr_reg <= 32'h0000_0013;
            cause_reg <= 3'd0;
            wait_reg  <= '0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (imem_ack) begin
                        instr_reg <= imem_rdata;
                        state_reg <= S_DECODE;
                        wait_reg  <= '0;
                    end else if (wait_expired) begin
                        state_reg <= S_HALT;
                        cause_reg <= CAUSE_TIMEOUT;
                        wait_reg  <= '0;
                    end else begin
                        wait_reg  <= wait_reg + 1'b1;
                    end
                end
                S_DECODE: begin
                    wait_reg <= '0;
                    if (opcode == 7'h73) begin
                        state_reg <= S_HALT;
                        cause_reg <= CAUSE_ECALL;
                    end else if (opcode_legal) begin
                        state_reg <= S_EXEC;
                    end else begin
                        state_reg <= S_HALT;
                        cause_reg <= CAUSE_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    wait_reg <= '0;
                    if ((opcode == 7'h03) || MemWrite) begin
                        state_reg <= S_MEM;
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        state_reg <= S_WB;
                        wait_reg  <= '0;
                    end else if (wait_expired) begin
                        state_reg <= S_HALT;
                        cause_reg <= CAUSE_TIMEOUT;
                        wait_reg  <= '0;
                    end else begin
                        wait_reg  <= wait_reg + 1'b1;
                    end
                end
                S_WB: begin
                    wait_reg <= '0;
                    if (next_pc_misaligned) begin
                        state_reg <= S_HALT;
                        cause_reg <= CAUSE_MISALIGN;
                    end else begin
                        pc_reg    <= next_pc;
                        state_reg <= S_FETCH;
                    end
                end
                S_HALT: begin
                    wait_reg <= '0;
                end
                default: begin
                    state_reg <= S_HALT;
                    wait_reg  <= '0;
                end
            endcase
        end
    end

`ifdef CORE_SEQ_INSTRET_EN
    logic [31:0] instret_reg;

    // Count every instruction that commits its PC in WB; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_reg <= '0;
        end else if (retire) begin
            instret_reg <= instret_reg + 32'd1;
        end
    end

    assign instret = instret_reg;
`else
    assign instret = 32'd0;
`endif

    // Strobes are decoded from the registered state and forced low during reset.
    assign imem_req   = !rst && (state_reg == S_FETCH);
    assign dmem_req   = !rst && (state_reg == S_MEM);
    assign dmem_we    = dmem_req && MemWrite;
    assign rf_we      = !rst && retire && RegWriteEn && (opcode != 7'h63) && (opcode != 7'h23);

    assign imem_addr  = pc_reg;
    assign pc         = pc_reg;
    assign instr      = instr_reg;
    assign halt       = (state_reg == S_HALT);
    assign trap_cause = cause_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: randomized bench for core_sequencer against a phase-level
// reference model. Honours CORE_SEQ_INSTRET_EN for the expected instret value.
module tb_core_sequencer;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam int          TMO = 4;

    localparam int PH_F = 0;
    localparam int PH_D = 1;
    localparam int PH_E = 2;
    localparam int PH_M = 3;
    localparam int PH_W = 4;
    localparam int PH_H = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        RegWriteEn;
    logic        MemWrite;
    logic [1:0]  PCSel;
    logic        branch_taken;
    logic [31:0] target;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halt;
    logic [2:0]  trap_cause;
    logic [31:0] instret;
    logic [2:0]  state;

    core_sequencer #(
        .RESET_VECTOR (RV),
        .BUS_TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .opcode       (opcode),
        .RegWriteEn   (RegWriteEn),
        .MemWrite     (MemWrite),
        .PCSel        (PCSel),
        .branch_taken (branch_taken),
        .target       (target),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .rf_we        (rf_we),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .halt         (halt),
        .trap_cause   (trap_cause),
        .instret      (instret),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference architectural state
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic [31:0] m_instr;
    logic [2:0]  m_cause;
    logic        m_halted;

    logic [6:0] legal_ops [8] = '{7'h03, 7'h13, 7'h1b, 7'h17, 7'h37, 7'h63, 7'h6f, 7'h23};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_instret();
`ifdef CORE_SEQ_INSTRET_EN
        return m_instret;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] h, input int s);
        return h * 32'd31 + 32'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc      = RV;
        m_instret = 32'd0;
        m_instr   = 32'h0000_0013;
        m_cause   = 3'd0;
        m_halted  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        RegWriteEn = 1'b1;
        MemWrite = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check_val("rst_state", 32'(state), PH_F);
            check_val("rst_pc", pc, RV);
            check_val("rst_instr", instr, 32'h0000_0013);
            check_val("rst_cause", 32'(trap_cause), 0);
            check_val("rst_instret", instret, 0);
            check_val("rst_halt", 32'(halt), 0);
            check_val("rst_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 0);
        end
        rst = 1'b0;
        model_reset();
        #1;
        check_val("first_imem_req", 32'(imem_req), 1);
    endtask

    // Run one instruction through fetch..writeback (or to a trap) with the given
    // ack delays (number of no-ack cycles before the ack), then compare outcome.
    task automatic run_instr(input string tag, input logic [31:0] word, input logic rwe,
                             input logic mw, input logic bt, input logic [31:0] tgt,
                             input int iw, input int dw);
        logic [6:0]  op;
        logic [31:0] e_h, o_h, npc;
        logic [2:0]  e_cause;
        int          e_cyc, e_dreq, e_dwe, e_rf;
        int          o_cyc, o_dreq, o_dwe, o_rf, icnt, dcnt;
        bit          left_fetch, done, is_mem;

        op = word[6:0];
        e_h = 0; o_h = 0; e_cause = 0; npc = 0;
        e_cyc = 0; e_dreq = 0; e_dwe = 0; e_rf = 0;
        o_cyc = 0; o_dreq = 0; o_dwe = 0; o_rf = 0; icnt = 0; dcnt = 0;
        left_fetch = 0; done = 0; is_mem = 0;

        check_val({tag, "_imem_addr"}, imem_addr, m_pc);
        check_val({tag, "_pc_plus4"}, pc_plus4, m_pc + 32'd4);

        // Reference: list the phases this instruction should visit
        if (iw >= TMO) begin
            for (int i = 0; i < TMO; i++) begin e_h = mix(e_h, PH_F); e_cyc++; end
            e_cause = 3'd4;
        end else begin
            for (int i = 0; i <= iw; i++) begin e_h = mix(e_h, PH_F); e_cyc++; end
            e_h = mix(e_h, PH_D); e_cyc++;
            m_instr = word;
            if (op == 7'h73) begin
                e_cause = 3'd3;
            end else if (!(op inside {7'h03, 7'h13, 7'h1b, 7'h17, 7'h37, 7'h63, 7'h6f, 7'h23})) begin
                e_cause = 3'd1;
            end else begin
                e_h = mix(e_h, PH_E); e_cyc++;
                is_mem = (op == 7'h03) || mw;
                if (is_mem) begin
                    e_dreq = (dw >= TMO) ? TMO : dw + 1;
                    e_dwe  = mw ? e_dreq : 0;
                    for (int i = 0; i < e_dreq; i++) begin e_h = mix(e_h, PH_M); e_cyc++; end
                    if (dw >= TMO) e_cause = 3'd4;
                end
                if (e_cause == 3'd0) begin
                    e_h = mix(e_h, PH_W); e_cyc++;
                    if (op == 7'h6f || (op == 7'h63 && bt)) npc = tgt;
                    else npc = m_pc + 32'd4;
                    if (npc[1:0] != 2'b00) begin
                        e_cause = 3'd2;
                    end else begin
                        m_pc = npc;
                        m_instret = m_instret + 32'd1;
                        e_rf = (rwe && op != 7'h63 && op != 7'h23) ? 1 : 0;
                    end
                end
            end
        end
        if (e_cause != 3'd0) begin
            m_cause  = e_cause;
            m_halted = 1'b1;
        end

        // Drive the decoder and memories cycle by cycle
        opcode = op; RegWriteEn = rwe; MemWrite = mw; branch_taken = bt; target = tgt;
        PCSel = (op == 7'h6f || (op == 7'h63 && bt)) ? 2'd1 : 2'd0;
        while (o_cyc < 64) begin
            if (state != 3'(PH_F)) left_fetch = 1;
            if (state == 3'(PH_H) || (left_fetch && state == 3'(PH_F))) begin
                done = 1;
                break;
            end
            imem_rdata = imem_req ? word : $urandom;
            imem_ack   = imem_req ? (icnt == iw) : 1'($urandom_range(0, 1));
            dmem_ack   = dmem_req ? (dcnt == dw) : 1'($urandom_range(0, 1));
            if (imem_req) icnt++;
            if (dmem_req) begin
                dcnt++;
                o_dreq++;
                if (dmem_we) o_dwe++;
            end
            if (rf_we) o_rf++;
            o_h = mix(o_h, int'(state));
            o_cyc++;
            tick();
        end

        check_val({tag, "_finished"}, 32'(done), 1);
        check_val({tag, "_cycles"}, o_cyc, e_cyc);
        check_val({tag, "_phases"}, o_h, e_h);
        check_val({tag, "_rf_we"}, o_rf, e_rf);
        check_val({tag, "_dmem_req"}, o_dreq, e_dreq);
        check_val({tag, "_dmem_we"}, o_dwe, e_dwe);
        check_val({tag, "_pc"}, pc, m_pc);
        check_val({tag, "_instret"}, instret, exp_instret());
        check_val({tag, "_instr"}, instr, m_instr);
        check_val({tag, "_halt"}, 32'(halt), 32'(m_halted));
        check_val({tag, "_cause"}, 32'(trap_cause), 32'(m_cause));
        $display("[TB] %-12s word=%h cycles=%0d pc=%h instret=%0d cause=%0d",
                 tag, word, o_cyc, pc, instret, trap_cause);
    endtask

    // While halted, hammer both acks and check nothing moves.
    task automatic hold_halted(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            imem_rdata = $urandom;
            tick();
            check_val("hold_state", 32'(state), PH_H);
            check_val("hold_pc", pc, m_pc);
            check_val("hold_instr", instr, m_instr);
            check_val("hold_cause", 32'(trap_cause), 32'(m_cause));
            check_val("hold_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 0);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    // Reset asserted during MEM with dmem_ack high in the same cycle.
    task automatic rst_mid_mem();
        opcode = 7'h03; RegWriteEn = 1'b1; MemWrite = 1'b0; branch_taken = 1'b0;
        imem_rdata = 32'h0000_2083;
        imem_ack = 1'b1;
        dmem_ack = 1'b0;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        check_val("midmem_state", 32'(state), PH_M);
        check_val("midmem_dmem_req", 32'(dmem_req), 1);
        rst = 1'b1;
        dmem_ack = 1'b1;
        #1;
        check_val("midmem_rst_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 0);
        tick();
        model_reset();
        check_val("midmem_next_state", 32'(state), PH_F);
        check_val("midmem_pc", pc, RV);
        check_val("midmem_instret", instret, 0);
        check_val("midmem_instr", instr, 32'h0000_0013);
        check_val("midmem_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 0);
        tick();
        check_val("midmem_hold_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 0);
        rst = 1'b0;
        dmem_ack = 1'b0;
        #1;
        check_val("midmem_restart_req", 32'(imem_req), 1);
        $display("[TB] %-12s pc=%h instret=%0d", "rst_mid_mem", pc, instret);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w, t;
        logic [6:0]  op;

        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; opcode = 7'h13;
        RegWriteEn = 1'b0; MemWrite = 1'b0; PCSel = 2'd0; branch_taken = 1'b0;
        target = 32'd0; dmem_ack = 1'b0;
        model_reset();

        do_reset(2);
        run_instr("addi",    32'h0050_0093, 1'b1, 1'b0, 1'b0, 32'h0,   0, 0);
        run_instr("lw_wait", 32'h0000_2083, 1'b1, 1'b0, 1'b0, 32'h0,   0, 2);
        run_instr("sw",      32'h0011_2023, 1'b1, 1'b1, 1'b0, 32'h0,   0, 0);
        run_instr("beq_tkn", 32'h0000_0063, 1'b1, 1'b0, 1'b1, 32'h40,  0, 0);
        run_instr("beq_ntk", 32'h0000_0063, 1'b0, 1'b0, 1'b0, 32'h80,  1, 0);
        run_instr("jal",     32'h0000_006f, 1'b1, 1'b0, 1'b0, 32'h100, 0, 0);

        for (int i = 0; i < 150; i++) begin
            op = legal_ops[$urandom_range(0, 7)];
            w = $urandom;
            w[6:0] = op;
            t = $urandom & 32'hFFFF_FFFC;
            run_instr("random", w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), t, $urandom_range(0, TMO - 1),
                      $urandom_range(0, TMO - 1));
        end

        run_instr("beq_misal", 32'h0000_0063, 1'b0, 1'b0, 1'b1, 32'h42, 0, 0);
        hold_halted(3);

        do_reset(2);
        run_instr("illegal", 32'h0000_007f, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
        hold_halted(3);

        do_reset(1);
        run_instr("ecall", 32'h0000_0073, 1'b0, 1'b0, 1'b0, 32'h0, 1, 0);
        hold_halted(2);

        do_reset(1);
        run_instr("imem_tmo", 32'h0050_0093, 1'b1, 1'b0, 1'b0, 32'h0, 10, 0);
        hold_halted(2);

        do_reset(1);
        run_instr("ack_at_lim", 32'h0050_0093, 1'b1, 1'b0, 1'b0, 32'h0, TMO - 1, 0);
        rst_mid_mem();
        run_instr("addi_again", 32'h0050_0093, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0);
        run_instr("dmem_tmo",   32'h0000_2083, 1'b1, 1'b0, 1'b0, 32'h0, 0, 10);
        hold_halted(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
